// File: rtl/key_input_pkg.sv
// key_input_pkg: scancodes, key indices and FSM encoding shared by the
// keyboard command path. Defining KEY_EVENT_PULSER_AUTOREPEAT_EN adds the
// HOLD state used by the auto-repeat option.
package key_input_pkg;

   // PS/2 set-2 make codes of the command keys
   localparam logic [8:0] KEY_W     = 9'h01D;
   localparam logic [8:0] KEY_A     = 9'h01C;
   localparam logic [8:0] KEY_S     = 9'h01B;
   localparam logic [8:0] KEY_D     = 9'h023;
   localparam logic [8:0] KEY_ENTER = 9'h05A;

   localparam int NUM_KEYS = 5;

   // Bit position of each command inside the one-hot pulse vector
   typedef enum logic [2:0] {
      K_UP = 3'd0,
      K_LT = 3'd1,
      K_DW = 3'd2,
      K_RT = 3'd3,
      K_CT = 3'd4
   } key_idx_t;

`ifdef KEY_EVENT_PULSER_AUTOREPEAT_EN
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOCK = 2'd1,
      ST_HOLD = 2'd2
   } state_t;
`else
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOCK = 2'd1
   } state_t;
`endif

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

   // Scancode belonging to a one-hot key vector (zero when nothing is set)
   function automatic logic [8:0] key_code(input logic [NUM_KEYS-1:0] oh);
      logic [8:0] code;
      code = 9'h000;
      if (oh[K_UP]) code = KEY_W;
      if (oh[K_LT]) code = KEY_A;
      if (oh[K_DW]) code = KEY_S;
      if (oh[K_RT]) code = KEY_D;
      if (oh[K_CT]) code = KEY_ENTER;
      return code;
   endfunction

endpackage

// File: rtl/key_code_match.sv
// key_code_match: maps a 9-bit scancode onto the one-hot command vector and
// flags whether it is one of the five command keys.
module key_code_match
   import key_input_pkg::*;
(
   input  logic [8:0]          i_code,
   output logic [NUM_KEYS-1:0] o_onehot,
   output logic                o_hit
);

   // Pure lookup, no state
   always_comb begin
      o_onehot = '0;
      case (i_code)
         KEY_W:     o_onehot[K_UP] = 1'b1;
         KEY_A:     o_onehot[K_LT] = 1'b1;
         KEY_S:     o_onehot[K_DW] = 1'b1;
         KEY_D:     o_onehot[K_RT] = 1'b1;
         KEY_ENTER: o_onehot[K_CT] = 1'b1;
         default:   o_onehot = '0;
      endcase
      o_hit = |o_onehot;
   end

endmodule

// File: rtl/key_event_pulser.sv
// key_event_pulser: turns Keyboard_Decoder level outputs into one-cycle
// W/A/S/D/Enter command pulses with a post-press lockout.
// Optional macro KEY_EVENT_PULSER_AUTOREPEAT_EN adds a HOLD state that
// re-issues the held key's pulse after REPEAT_DELAY, then every REPEAT_PERIOD.
//
// Handshake: key_valid is a level strobe; only its rising edge (key_valid=1
// while the registered copy is 0) is an event. Pulses are registered and
// appear exactly one cycle after the event, at most one pulse per cycle.
module key_event_pulser
   import key_input_pkg::*;
#(
   parameter int LOCKOUT_CYCLES = 1000000,
   parameter int REPEAT_DELAY   = 50000000,
   parameter int REPEAT_PERIOD  = 10000000
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [511:0] key_down,
   input  logic [8:0]   last_change,
   input  logic         key_valid,
   output logic         up_pulse,
   output logic         lt_pulse,
   output logic         dw_pulse,
   output logic         rt_pulse,
   output logic         ct_pulse,
   output logic         busy,
   output state_t       dbg_state
);

   localparam int CNT_W = $clog2(max3(LOCKOUT_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)) + 1;
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] LOCK_LOAD = CNT_W'(LOCKOUT_CYCLES - 1);
`ifdef KEY_EVENT_PULSER_AUTOREPEAT_EN
   // First repeat lands REPEAT_DELAY cycles after the original pulse; the
   // lockout already consumed LOCKOUT_CYCLES of that wait.
   localparam int HOLD_DELAY_I = (REPEAT_DELAY - LOCKOUT_CYCLES - 1 > 0) ?
                                 (REPEAT_DELAY - LOCKOUT_CYCLES - 1) : 0;
   localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_DELAY_I);
   localparam logic [CNT_W-1:0] REP_LOAD  = CNT_W'(REPEAT_PERIOD - 1);
`endif

   logic                r_kv_q;
   state_t              r_state;
   logic [CNT_W-1:0]    r_cnt;
   logic [NUM_KEYS-1:0] r_pulse;
   logic [NUM_KEYS-1:0] w_onehot;
   logic                w_hit;
   logic                w_event;
   logic                w_press;
`ifdef KEY_EVENT_PULSER_AUTOREPEAT_EN
   logic [NUM_KEYS-1:0] r_key;
   logic [CNT_W-1:0]    r_rcnt;
   logic                w_key_held;
`endif

   key_code_match u_match (
      .i_code   (last_change),
      .o_onehot (w_onehot),
      .o_hit    (w_hit)
   );

   // A press is a rising edge of key_valid on a command key that is now down
   assign w_event = key_valid & ~r_kv_q;
   assign w_press = w_event & w_hit & key_down[last_change];
`ifdef KEY_EVENT_PULSER_AUTOREPEAT_EN
   assign w_key_held = key_down[key_code(r_key)];
`endif

   // Event edge detector, lockout/repeat FSM and registered pulse outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         r_kv_q  <= 1'b0;
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_pulse <= '0;
`ifdef KEY_EVENT_PULSER_AUTOREPEAT_EN
         r_key   <= '0;
         r_rcnt  <= '0;
`endif
      end else begin
         r_kv_q  <= key_valid;
         r_pulse <= '0;
         case (r_state)
            ST_IDLE: begin
               if (w_press) begin
                  r_pulse <= w_onehot;
                  r_cnt   <= LOCK_LOAD;
                  r_state <= ST_LOCK;
`ifdef KEY_EVENT_PULSER_AUTOREPEAT_EN
                  r_key   <= w_onehot;
`endif
               end
            end
            ST_LOCK: begin
               // Presses are dropped here, including one in the exit cycle
               if (r_cnt == '0) begin
`ifdef KEY_EVENT_PULSER_AUTOREPEAT_EN
                  if (w_key_held) begin
                     r_rcnt  <= HOLD_LOAD;
                     r_state <= ST_HOLD;
                  end else begin
                     r_state <= ST_IDLE;
                  end
`else
                  r_state <= ST_IDLE;
`endif
               end else begin
                  r_cnt <= r_cnt - CNT_ONE;
               end
            end
`ifdef KEY_EVENT_PULSER_AUTOREPEAT_EN
            ST_HOLD: begin
               if (w_press && (w_onehot != r_key)) begin
                  // Another key takes over as a fresh press
                  r_pulse <= w_onehot;
                  r_cnt   <= LOCK_LOAD;
                  r_key   <= w_onehot;
                  r_state <= ST_LOCK;
               end else if (!w_key_held) begin
                  r_state <= ST_IDLE;
               end else if (r_rcnt == '0) begin
                  r_pulse <= r_key;
                  r_rcnt  <= REP_LOAD;
               end else begin
                  r_rcnt <= r_rcnt - CNT_ONE;
               end
            end
`endif
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign up_pulse  = r_pulse[K_UP];
   assign lt_pulse  = r_pulse[K_LT];
   assign dw_pulse  = r_pulse[K_DW];
   assign rt_pulse  = r_pulse[K_RT];
   assign ct_pulse  = r_pulse[K_CT];
   assign busy      = (r_state != ST_IDLE);
   assign dbg_state = r_state;

endmodule

// File: tb/tb_key_event_pulser.sv
// tb_key_event_pulser: directed scenarios plus random key traffic, checked
// every cycle against a deadline-based reference model of the pulser.
`timescale 1ns/1ps
module tb_key_event_pulser;
   import key_input_pkg::*;

   localparam int L  = 8;
   localparam int RD = 20;
   localparam int RP = 5;
`ifdef KEY_EVENT_PULSER_AUTOREPEAT_EN
   localparam bit AR = 1'b1;
`else
   localparam bit AR = 1'b0;
`endif
   localparam int HOLD_DELAY = (RD - L - 1 > 0) ? (RD - L - 1) : 0;

   // ---------------- clock / reset / DUT ----------------
   logic         clk = 1'b0;
   logic         rst;
   logic [511:0] kd;
   logic [8:0]   last_change;
   logic         key_valid;
   logic         up_pulse, lt_pulse, dw_pulse, rt_pulse, ct_pulse, busy;
   state_t       dbg_state;

   always #5 clk = ~clk;

   key_event_pulser #(
      .LOCKOUT_CYCLES (L),
      .REPEAT_DELAY   (RD),
      .REPEAT_PERIOD  (RP)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .key_down    (kd),
      .last_change (last_change),
      .key_valid   (key_valid),
      .up_pulse    (up_pulse),
      .lt_pulse    (lt_pulse),
      .dw_pulse    (dw_pulse),
      .rt_pulse    (rt_pulse),
      .ct_pulse    (ct_pulse),
      .busy        (busy),
      .dbg_state   (dbg_state)
   );

   // ---------------- scoreboard state ----------------
   int         n_checks = 0;
   int         n_fail   = 0;
   int         cyc      = 0;
   int         n_pulses = 0;
   logic [5:0] exp_q[$];   // {busy, ct, rt, dw, lt, up} expected after the edge

   // Reference model: absolute-cycle deadlines instead of counters
   logic       m_kv      = 1'b0;
   int         lock_end  = -100;   // last cycle in which presses are dropped
   logic [8:0] lock_code = 9'h000;
   bit         hold      = 1'b0;
   int         next_rep  = 0;      // cycle whose edge issues the next repeat

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
      end
   endtask

   function automatic int slot_of(input logic [8:0] c);
      case (c)
         KEY_W:     return 0;
         KEY_A:     return 1;
         KEY_S:     return 2;
         KEY_D:     return 3;
         KEY_ENTER: return 4;
         default:   return -1;
      endcase
   endfunction

   // Predicts outputs for cycle cyc+1 from the inputs of cycle cyc
   task automatic model_step();
      logic [5:0] e;
      bit         ev, press;
      int         s;
      e = '0;
      if (rst) begin
         m_kv     = 1'b0;
         lock_end = -100;
         hold     = 1'b0;
      end else begin
         ev    = key_valid && !m_kv;
         m_kv  = key_valid;
         s     = slot_of(last_change);
         press = ev && (s >= 0) && kd[last_change];
         if (cyc <= lock_end) begin
            if (AR && (cyc == lock_end) && kd[lock_code]) begin
               hold     = 1'b1;
               next_rep = cyc + 1 + HOLD_DELAY;
            end
         end else if (hold) begin
            if (press && (last_change != lock_code)) begin
               e[s] = 1'b1;
               lock_end  = cyc + L;
               lock_code = last_change;
               hold      = 1'b0;
            end else if (!kd[lock_code]) begin
               hold = 1'b0;
            end else if (cyc == next_rep) begin
               e[slot_of(lock_code)] = 1'b1;
               next_rep = cyc + RP;
            end
         end else if (press) begin
            e[s] = 1'b1;
            lock_end  = cyc + L;
            lock_code = last_change;
         end
         e[5] = ((cyc + 1) <= lock_end) || hold;
      end
      exp_q.push_back(e);
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      logic [5:0] got, exp;
      model_step();
      @(posedge clk);
      #1;
      got = {busy, ct_pulse, rt_pulse, dw_pulse, lt_pulse, up_pulse};
      exp = exp_q.pop_front();
      check_eq("outputs", 32'(got), 32'(exp));
      if (|got[4:0]) n_pulses++;
      cyc++;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic press(input logic [8:0] c, input int n);
      last_change = c;
      kd[c]       = 1'b1;
      key_valid   = 1'b1;
      repeat (n) tick();
      key_valid   = 1'b0;
   endtask

   task automatic brk(input logic [8:0] c, input int n);
      last_change = c;
      kd[c]       = 1'b0;
      key_valid   = 1'b1;
      repeat (n) tick();
      key_valid   = 1'b0;
   endtask

   function automatic logic [8:0] pick_code();
      case ($urandom_range(0, 6))
         0:       return KEY_W;
         1:       return KEY_A;
         2:       return KEY_S;
         3:       return KEY_D;
         4:       return KEY_ENTER;
         5:       return 9'h029;
         default: return 9'($urandom_range(0, 511));
      endcase
   endfunction

   // ---------------- stimulus ----------------
   initial begin
      int p0;
      rst         = 1'b1;
      kd          = '0;
      last_change = 9'h000;
      key_valid   = 1'b0;
      idle(2);
      check_eq("reset_busy", 32'(busy), 32'd0);
      check_eq("reset_pulses", 32'({ct_pulse, rt_pulse, dw_pulse, lt_pulse, up_pulse}), 32'd0);
      rst = 1'b0;
      idle(5);

      // Single W press, key_valid high three cycles
      p0 = n_pulses;
      press(KEY_W, 3);
      kd[KEY_W] = 1'b0;
      idle(20);
      check_eq("w_single_pulse", 32'(n_pulses - p0), 32'd1);

      // Enter break, then an unrelated scancode
      p0 = n_pulses;
      brk(KEY_ENTER, 2);
      idle(3);
      press(9'h029, 2);
      kd[9'h029] = 1'b0;
      idle(12);
      check_eq("break_unknown_pulses", 32'(n_pulses - p0), 32'd0);

      // Lockout drops S, later S is accepted
      p0 = n_pulses;
      press(KEY_D, 2);
      kd[KEY_D] = 1'b0;
      idle(2);
      press(KEY_S, 2);
      kd[KEY_S] = 1'b0;
      idle(14);
      press(KEY_S, 2);
      kd[KEY_S] = 1'b0;
      idle(20);
      check_eq("lockout_pulses", 32'(n_pulses - p0), 32'd2);

      // Reset in the middle of LOCK, then Enter
      p0 = n_pulses;
      press(KEY_A, 2);
      kd[KEY_A] = 1'b0;
      idle(1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_eq("reset_mid_lock_busy", 32'(busy), 32'd0);
      idle(2);
      press(KEY_ENTER, 2);
      kd[KEY_ENTER] = 1'b0;
      idle(20);
      check_eq("reset_mid_lock_pulses", 32'(n_pulses - p0), 32'd2);

      // W held for 33 cycles
      p0 = n_pulses;
      press(KEY_W, 3);
      idle(30);
      kd[KEY_W] = 1'b0;
      idle(15);
      check_eq("hold_w_pulses", 32'(n_pulses - p0), AR ? 32'd4 : 32'd1);
      check_eq("hold_w_idle_busy", 32'(busy), 32'd0);

      // Random decoder traffic
      for (int i = 0; i < 1500; i++) begin
         logic [8:0] c;
         rst = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 2) == 0) begin
            key_valid = ~key_valid;
            if (key_valid) begin
               last_change     = pick_code();
               kd[last_change] = ($urandom_range(0, 3) != 0);
            end
         end
         if ($urandom_range(0, 15) == 0) begin
            c     = pick_code();
            kd[c] = ~kd[c];
         end
         tick();
      end
      rst = 1'b0;
      key_valid = 1'b0;
      idle(5);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
